alu_cmd_sequencer: RTL and testbench

- Clocked command front-end for the combinational `alu`. It accepts operations over a valid/ready command channel, drives A/B/opCode into the ALU, waits a fixed settle time, then captures Out/Carry_out/C_flag.
- Captured results are returned on a valid/ready response channel.
- It replaces free-running stimulus driving of the ALU in system and bench contexts, and keeps running operation/carry statistics.

---
 rtl/alu_cmd_sequencer.sv | 236 +++++++++++++++++++++++
 tb/tb_alu_cmd_sequencer.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_sequencer.sv
// ---------------------------------------------------------------------------
// alu_cmd_sequencer
//   Clocked command front-end for a combinational ALU. A command accepted on
//   the cmd_* valid/ready channel is registered onto alu_A/alu_B/alu_opCode.
//   The sequencer waits SETTLE cycles, captures the ALU result and returns it
//   on the rsp_* valid/ready channel. Running statistics count completed
//   responses and responses that carried out.
//
// Parameters
//   WIDTH  : operand/result width
//   SETTLE : edges from command acceptance to result capture (1..15)
//   CNT_W  : statistics counter width (counters wrap)
//
// Ports
//   clk, rst_n                        clock, async active-low reset
//   cmd_valid/cmd_ready/cmd_a/b/op    command channel
//   alu_A/alu_B/alu_opCode            registered ALU drive
//   alu_Out/alu_Carry_out/alu_C_flag  ALU result inputs
//   rsp_valid/rsp_ready/rsp_*         response channel (captured values)
//   busy                              operation in flight (WAIT or RESP)
//   cnt_clr                           synchronous clear of the counters
//   op_count/carry_count              statistics
//
// Optional feature (macro ALU_SEQ_CHECK_EN)
//   Adds a golden model of the ALU evaluated at capture, plus ports
//   chk_err (sticky until next accept) and err_count (mismatch count).
// ---------------------------------------------------------------------------
module alu_cmd_sequencer #(
  parameter int WIDTH  = 8,
  parameter int SETTLE = 1,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  input  logic [2:0]       cmd_op,
  output logic [WIDTH-1:0] alu_A,
  output logic [WIDTH-1:0] alu_B,
  output logic [2:0]       alu_opCode,
  input  logic [WIDTH-1:0] alu_Out,
  input  logic             alu_Carry_out,
  input  logic             alu_C_flag,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_out,
  output logic             rsp_carry,
  output logic             rsp_cflag,
  output logic [2:0]       rsp_op,
  output logic             busy,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] op_count,
  output logic [CNT_W-1:0] carry_count
`ifdef ALU_SEQ_CHECK_EN
  ,
  output logic             chk_err,
  output logic [CNT_W-1:0] err_count
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Counter load value: the capture edge is SETTLE edges after acceptance.
  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE - 1);

  state_t           r_state;
  logic [3:0]       r_settle;
  logic [WIDTH-1:0] r_alu_a;
  logic [WIDTH-1:0] r_alu_b;
  logic [2:0]       r_alu_op;
  logic             r_rsp_valid;
  logic [WIDTH-1:0] r_rsp_out;
  logic             r_rsp_carry;
  logic             r_rsp_cflag;
  logic [2:0]       r_rsp_op;
  logic             r_busy;
  logic [CNT_W-1:0] r_op_count;
  logic [CNT_W-1:0] r_carry_count;

  logic w_capture;
  logic w_rsp_fire;
  logic w_cmd_fire;

  assign w_cmd_fire = cmd_valid && (r_state == ST_IDLE);
  assign w_capture  = (r_state == ST_WAIT) && (r_settle == 4'd0);
  assign w_rsp_fire = r_rsp_valid && rsp_ready;

  // cmd_ready is a pure decode of the state register (no input paths).
  assign cmd_ready   = (r_state == ST_IDLE);
  assign alu_A       = r_alu_a;
  assign alu_B       = r_alu_b;
  assign alu_opCode  = r_alu_op;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_out     = r_rsp_out;
  assign rsp_carry   = r_rsp_carry;
  assign rsp_cflag   = r_rsp_cflag;
  assign rsp_op      = r_rsp_op;
  assign busy        = r_busy;
  assign op_count    = r_op_count;
  assign carry_count = r_carry_count;

  // Sequencer FSM: accept, settle, capture, hand the response back.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_settle    <= 4'd0;
      r_alu_a     <= '0;
      r_alu_b     <= '0;
      r_alu_op    <= 3'd0;
      r_rsp_valid <= 1'b0;
      r_rsp_out   <= '0;
      r_rsp_carry <= 1'b0;
      r_rsp_cflag <= 1'b0;
      r_rsp_op    <= 3'd0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (cmd_valid) begin
            r_alu_a  <= cmd_a;
            r_alu_b  <= cmd_b;
            r_alu_op <= cmd_op;
            r_settle <= SETTLE_LOAD;
            r_busy   <= 1'b1;
            r_state  <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (r_settle == 4'd0) begin
            // Only the captured copy is presented; later ALU activity is ignored.
            r_rsp_out   <= alu_Out;
            r_rsp_carry <= alu_Carry_out;
            r_rsp_cflag <= alu_C_flag;
            r_rsp_op    <= r_alu_op;
            r_rsp_valid <= 1'b1;
            r_state     <= ST_RESP;
          end else begin
            r_settle <= r_settle - 4'd1;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_rsp_valid <= 1'b0;
          r_busy      <= 1'b0;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

  // Statistics counters; a clear wins over a same-edge increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op_count    <= '0;
      r_carry_count <= '0;
    end else if (cnt_clr) begin
      r_op_count    <= '0;
      r_carry_count <= '0;
    end else if (w_rsp_fire) begin
      r_op_count <= r_op_count + CNT_W'(1);
      if (r_rsp_carry) begin
        r_carry_count <= r_carry_count + CNT_W'(1);
      end
    end
  end

`ifdef ALU_SEQ_CHECK_EN
  // Reference ALU result {carry, out} for the currently driven operation.
  function automatic logic [WIDTH:0] golden_alu(
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b,
    input logic [2:0]       op
  );
    logic [WIDTH:0] res;
    res = '0;
    case (op)
      3'b000:  res = {1'b0, a} + {1'b0, b};
      3'b001:  res = {(a < b), a - b};
      3'b010:  res = {1'b0, a & b};
      3'b011:  res = {1'b0, a | b};
      3'b100:  res = {1'b0, a ^ b};
      3'b110:  res = {a[WIDTH-1], a[WIDTH-2:0], 1'b0};
      3'b111:  res = {b[WIDTH-1], b[WIDTH-2:0], 1'b0};
      default: res = '0;
    endcase
    return res;
  endfunction

  logic [WIDTH:0]   w_gold;
  logic             w_mismatch;
  logic             r_chk_err;
  logic [CNT_W-1:0] r_err_count;

  assign w_gold     = golden_alu(r_alu_a, r_alu_b, r_alu_op);
  // CMP has no defined Out/Carry, so it is never flagged.
  assign w_mismatch = w_capture && (r_alu_op != 3'b101) &&
                      ({alu_Carry_out, alu_Out} != w_gold);
  assign chk_err    = r_chk_err;
  assign err_count  = r_err_count;

  // Mismatch flag: evaluated at capture, cleared on the next acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_chk_err <= 1'b0;
    end else if (w_cmd_fire) begin
      r_chk_err <= 1'b0;
    end else if (w_capture) begin
      r_chk_err <= w_mismatch;
    end
  end

  // Mismatch counter, cleared together with the statistics.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_count <= '0;
    end else if (cnt_clr) begin
      r_err_count <= '0;
    end else if (w_mismatch) begin
      r_err_count <= r_err_count + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Self-checking bench for alu_cmd_sequencer. Two instances are exercised:
// u0 (SETTLE=3, CNT_W=4) and u1 (SETTLE=1, CNT_W=16). A behavioural ALU
// feeds each instance; expected responses and counters come from a model
// of the command semantics kept in this bench.
module tb_alu_cmd_sequencer;

  logic clk;
  logic rst_n;

  logic [1:0]      cmd_valid, cmd_ready, rsp_valid, rsp_ready, busy, cnt_clr;
  logic [1:0][7:0] cmd_a, cmd_b, alu_A, alu_B, alu_Out, rsp_out;
  logic [1:0][2:0] cmd_op, alu_op, rsp_op;
  logic [1:0]      alu_co, alu_cf, rsp_carry, rsp_cflag;
  logic [1:0]      inject;
  logic [1:0][9:0] alu_res;
  logic [3:0]      op_cnt0, car_cnt0;
  logic [15:0]     op_cnt1, car_cnt1;
`ifdef ALU_SEQ_CHECK_EN
  logic [1:0]      chk_err;
  logic [3:0]      err_cnt0;
  logic [15:0]     err_cnt1;
`endif

  int n_assert = 0;
  int n_fail   = 0;
  int unsigned m_ops[2];
  int unsigned m_car[2];
  int unsigned m_err[2];

  // Behavioural ALU: returns {cflag, carry, out}
  function automatic logic [9:0] alu_model(input logic [7:0] a, input logic [7:0] b,
                                           input logic [2:0] op);
    int r;
    logic [7:0] o;
    logic c;
    logic f;
    r = 0; o = 8'h00; c = 1'b0; f = 1'b0;
    case (op)
      3'd0: begin r = int'(a) + int'(b); o = r[7:0]; c = (r > 255); end
      3'd1: begin r = int'(a) - int'(b); o = r[7:0]; c = (int'(a) < int'(b)); end
      3'd2: o = a & b;
      3'd3: o = a | b;
      3'd4: o = a ^ b;
      3'd5: f = (int'(a) >= int'(b));
      3'd6: begin r = int'(a) * 2; o = r[7:0]; c = (int'(a) >= 128); end
      default: begin r = int'(b) * 2; o = r[7:0]; c = (int'(b) >= 128); end
    endcase
    return {f, c, o};
  endfunction

  assign alu_res[0] = alu_model(alu_A[0], alu_B[0], alu_op[0]);
  assign alu_res[1] = alu_model(alu_A[1], alu_B[1], alu_op[1]);
  assign alu_Out[0] = inject[0] ? 8'h12 : alu_res[0][7:0];
  assign alu_Out[1] = inject[1] ? 8'h12 : alu_res[1][7:0];
  assign alu_co     = {alu_res[1][8], alu_res[0][8]};
  assign alu_cf     = {alu_res[1][9], alu_res[0][9]};

  alu_cmd_sequencer #(.WIDTH(8), .SETTLE(3), .CNT_W(4)) u0 (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]),
    .cmd_a(cmd_a[0]), .cmd_b(cmd_b[0]), .cmd_op(cmd_op[0]),
    .alu_A(alu_A[0]), .alu_B(alu_B[0]), .alu_opCode(alu_op[0]),
    .alu_Out(alu_Out[0]), .alu_Carry_out(alu_co[0]), .alu_C_flag(alu_cf[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
    .rsp_out(rsp_out[0]), .rsp_carry(rsp_carry[0]), .rsp_cflag(rsp_cflag[0]),
    .rsp_op(rsp_op[0]), .busy(busy[0]), .cnt_clr(cnt_clr[0]),
`ifdef ALU_SEQ_CHECK_EN
    .chk_err(chk_err[0]), .err_count(err_cnt0),
`endif
    .op_count(op_cnt0), .carry_count(car_cnt0)
  );

  alu_cmd_sequencer #(.WIDTH(8), .SETTLE(1), .CNT_W(16)) u1 (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]),
    .cmd_a(cmd_a[1]), .cmd_b(cmd_b[1]), .cmd_op(cmd_op[1]),
    .alu_A(alu_A[1]), .alu_B(alu_B[1]), .alu_opCode(alu_op[1]),
    .alu_Out(alu_Out[1]), .alu_Carry_out(alu_co[1]), .alu_C_flag(alu_cf[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
    .rsp_out(rsp_out[1]), .rsp_carry(rsp_carry[1]), .rsp_cflag(rsp_cflag[1]),
    .rsp_op(rsp_op[1]), .busy(busy[1]), .cnt_clr(cnt_clr[1]),
`ifdef ALU_SEQ_CHECK_EN
    .chk_err(chk_err[1]), .err_count(err_cnt1),
`endif
    .op_count(op_cnt1), .carry_count(car_cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int unsigned cmod(input int s);
    return (s == 0) ? 16 : 65536;
  endfunction

  function automatic int unsigned settle_of(input int s);
    return (s == 0) ? 3 : 1;
  endfunction

  function automatic logic [31:0] opc(input int s);
    return (s == 0) ? 32'(op_cnt0) : 32'(op_cnt1);
  endfunction

  function automatic logic [31:0] carc(input int s);
    return (s == 0) ? 32'(car_cnt0) : 32'(car_cnt1);
  endfunction

`ifdef ALU_SEQ_CHECK_EN
  function automatic logic [31:0] errc(input int s);
    return (s == 0) ? 32'(err_cnt0) : 32'(err_cnt1);
  endfunction
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete operation on instance s, checked against the model.
  task automatic run_op(input int s, input logic [7:0] a, input logic [7:0] b,
                        input logic [2:0] op, input int hold, input bit early,
                        input bit clr_hs, input bit inj);
    logic [9:0] exp;
    int n;
    exp = alu_model(a, b, op);
    if (inj) exp[7:0] = 8'h12;
    n = 0;
    while (!cmd_ready[s] && n < 50) begin tick(); n++; end
    chk("cmd_ready_idle", 32'(cmd_ready[s]), 32'd1);
    cmd_valid[s] = 1'b1; cmd_a[s] = a; cmd_b[s] = b; cmd_op[s] = op;
    rsp_ready[s] = early; inject[s] = inj;
    tick();
    cmd_valid[s] = 1'b0;
    cmd_a[s] = 8'($urandom); cmd_b[s] = 8'($urandom); cmd_op[s] = 3'($urandom);
    chk("alu_A_after_accept", 32'(alu_A[s]), 32'(a));
    chk("alu_B_after_accept", 32'(alu_B[s]), 32'(b));
    chk("alu_op_after_accept", 32'(alu_op[s]), 32'(op));
    chk("busy_after_accept", 32'(busy[s]), 32'd1);
    chk("cmd_ready_busy", 32'(cmd_ready[s]), 32'd0);
`ifdef ALU_SEQ_CHECK_EN
    chk("chk_err_after_accept", 32'(chk_err[s]), 32'd0);
`endif
    n = 0;
    while (!rsp_valid[s] && n < 40) begin tick(); n++; end
    chk("capture_latency", 32'(n), 32'(settle_of(s)));
    chk("rsp_valid", 32'(rsp_valid[s]), 32'd1);
    chk("rsp_out", 32'(rsp_out[s]), 32'(exp[7:0]));
    chk("rsp_carry", 32'(rsp_carry[s]), 32'(exp[8]));
    chk("rsp_cflag", 32'(rsp_cflag[s]), 32'(exp[9]));
    chk("rsp_op", 32'(rsp_op[s]), 32'(op));
`ifdef ALU_SEQ_CHECK_EN
    if (inj) m_err[s] = (m_err[s] + 1) % cmod(s);
    chk("chk_err_at_capture", 32'(chk_err[s]), 32'(inj));
    chk("err_count", errc(s), 32'(m_err[s]));
`endif
    if (!early) begin
      // Back-pressure: live ALU output wiggles, response must not move.
      for (int h = 0; h < hold; h++) begin
        inject[s] = ~inject[s];
        tick();
        chk("hold_valid", 32'(rsp_valid[s]), 32'd1);
        chk("hold_out", 32'(rsp_out[s]), 32'(exp[7:0]));
        chk("hold_carry", 32'(rsp_carry[s]), 32'(exp[8]));
        chk("hold_cmd_ready", 32'(cmd_ready[s]), 32'd0);
      end
    end
    inject[s] = 1'b0; rsp_ready[s] = 1'b1; cnt_clr[s] = clr_hs;
    tick();
    rsp_ready[s] = 1'b0; cnt_clr[s] = 1'b0;
    if (clr_hs) begin
      m_ops[s] = 0; m_car[s] = 0; m_err[s] = 0;
    end else begin
      m_ops[s] = (m_ops[s] + 1) % cmod(s);
      m_car[s] = (m_car[s] + 32'(exp[8])) % cmod(s);
    end
    chk("rsp_valid_after_hs", 32'(rsp_valid[s]), 32'd0);
    chk("cmd_ready_after_hs", 32'(cmd_ready[s]), 32'd1);
    chk("busy_after_hs", 32'(busy[s]), 32'd0);
    chk("alu_A_held", 32'(alu_A[s]), 32'(a));
    chk("op_count", opc(s), 32'(m_ops[s]));
    chk("carry_count", carc(s), 32'(m_car[s]));
`ifdef ALU_SEQ_CHECK_EN
    chk("err_count_after_hs", errc(s), 32'(m_err[s]));
`endif
  endtask

  task automatic chk_reset_outputs(input int s);
    chk("rst_alu_A", 32'(alu_A[s]), 32'd0);
    chk("rst_alu_B", 32'(alu_B[s]), 32'd0);
    chk("rst_alu_op", 32'(alu_op[s]), 32'd0);
    chk("rst_rsp_out", 32'(rsp_out[s]), 32'd0);
    chk("rst_rsp_op", 32'(rsp_op[s]), 32'd0);
    chk("rst_rsp_carry", 32'(rsp_carry[s]), 32'd0);
    chk("rst_rsp_cflag", 32'(rsp_cflag[s]), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid[s]), 32'd0);
    chk("rst_busy", 32'(busy[s]), 32'd0);
    chk("rst_op_count", opc(s), 32'd0);
    chk("rst_carry_count", carc(s), 32'd0);
  endtask

  initial begin
    int s;
    int hold;
    bit early;
    rst_n = 1'b0;
    cmd_valid = '0; rsp_ready = '0; cnt_clr = '0; inject = '0;
    cmd_a = '0; cmd_b = '0; cmd_op = '0;
    for (int i = 0; i < 2; i++) begin m_ops[i] = 0; m_car[i] = 0; m_err[i] = 0; end

    // Power-on reset
    @(posedge clk); @(posedge clk); #1;
    chk_reset_outputs(0);
    chk_reset_outputs(1);
    @(negedge clk); rst_n = 1'b1;
    tick();
    chk("cmd_ready_after_reset_u0", 32'(cmd_ready[0]), 32'd1);
    chk("cmd_ready_after_reset_u1", 32'(cmd_ready[1]), 32'd1);

    // ADD without carry, ready already high (SETTLE=1)
    run_op(1, 8'h0D, 8'h06, 3'b000, 0, 1'b1, 1'b0, 1'b0);
    chk("add_op_count_1", opc(1), 32'd1);
    // ADD with carry under 5 cycles of back-pressure
    run_op(1, 8'hFF, 8'h01, 3'b000, 5, 1'b0, 1'b0, 1'b0);
    chk("add_carry_count_1", carc(1), 32'd1);
    // SUB with borrow (SETTLE=3)
    run_op(0, 8'h01, 8'h02, 3'b001, 1, 1'b0, 1'b0, 1'b0);

    // Ignored command during WAIT, then reset mid-operation
    cmd_valid[0] = 1'b1; cmd_a[0] = 8'h3C; cmd_b[0] = 8'h11; cmd_op[0] = 3'b000;
    tick();
    cmd_a[0] = 8'hAA; cmd_b[0] = 8'h55;
    tick();
    cmd_valid[0] = 1'b0;
    chk("ignored_cmd_alu_A", 32'(alu_A[0]), 32'h3C);
    chk("ignored_cmd_busy", 32'(busy[0]), 32'd1);
    chk("ignored_cmd_no_rsp", 32'(rsp_valid[0]), 32'd0);
    rst_n = 1'b0;
    #2;
    for (int i = 0; i < 2; i++) begin m_ops[i] = 0; m_car[i] = 0; m_err[i] = 0; end
    chk_reset_outputs(0);
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("post_reset_no_rsp", 32'(rsp_valid[0]), 32'd0);
      chk("post_reset_not_AA", 32'(alu_A[0] == 8'hAA), 32'd0);
    end
    chk("post_reset_cmd_ready", 32'(cmd_ready[0]), 32'd1);
    run_op(0, 8'h21, 8'h0F, 3'b011, 0, 1'b0, 1'b0, 1'b0);

    // 16 back-to-back ops wrap the 4-bit counter, then clear on a handshake
    run_op(0, 8'h00, 8'h00, 3'b010, 0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 16; i++) begin
      run_op(0, 8'($urandom), 8'($urandom), 3'($urandom), 0, 1'($urandom), 1'b0, 1'b0);
    end
    chk("op_count_wrapped", opc(0), 32'd0);
    run_op(0, 8'hF0, 8'h20, 3'b000, 0, 1'b1, 1'b1, 1'b0);
    chk("clr_on_hs_op_count", opc(0), 32'd0);
    chk("clr_on_hs_carry_count", carc(0), 32'd0);

`ifdef ALU_SEQ_CHECK_EN
    // Forced wrong ALU result must be flagged, and clear on the next accept
    run_op(1, 8'h0D, 8'h06, 3'b000, 0, 1'b0, 1'b0, 1'b1);
    chk("chk_err_sticky", 32'(chk_err[1]), 32'd1);
    chk("err_count_one", errc(1), 32'd1);
    run_op(1, 8'h40, 8'h02, 3'b001, 0, 1'b0, 1'b0, 1'b0);
    chk("chk_err_clean_op", 32'(chk_err[1]), 32'd0);
`endif

    // Randomized operations on both instances
    for (int i = 0; i < 40; i++) begin
      s = int'($urandom_range(0, 1));
      hold = int'($urandom_range(0, 3));
      early = (hold == 0) ? 1'($urandom) : 1'b0;
      run_op(s, 8'($urandom), 8'($urandom), 3'($urandom), hold, early,
             ($urandom_range(0, 9) == 0), 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
